// File: rtl/fetch_pkg.sv
// Shared constants and the fetch queue entry record.
// No ports; imported by fetch_entry_fifo and fetch_queue.
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0100_0000;
  localparam logic [31:0] DEF_KILL_INSTR = 32'h0000_0013;

  // Widest PC any instance may use; narrower instances use the low bits.
  localparam int MAX_XLEN = 64;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [31:0]         instr;
    logic                filled;
  } entry_t;

endpackage

// File: rtl/fetch_entry_fifo.sv
// In-order entry storage: allocate (pc), fill (instr), pop (head), flush.
// Ports: clock/reset, flush, alloc_*, fill_*, pop_en, head_*, alloc/fill counts.
module fetch_entry_fifo
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill_en,
  input  logic [31:0]              fill_instr,
  input  logic                     pop_en,
  output logic                     head_valid,
  output logic [XLEN-1:0]          head_pc,
  output logic [31:0]              head_instr,
  output logic [$clog2(DEPTH):0]   alloc_count,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        ent [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] aptr;
  logic [AW-1:0] fptr;

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      head        <= '0;
      aptr        <= '0;
      fptr        <= '0;
      alloc_count <= '0;
      fill_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].filled <= 1'b0;
      end
    end else begin
      if (pop_en) begin
        ent[head].filled <= 1'b0;
        head             <= head + 1'b1;
      end
      // Responses return in order, so fills walk the
      // allocated entries oldest first.
      if (fill_en) begin
        ent[fptr].instr  <= fill_instr;
        ent[fptr].filled <= 1'b1;
        fptr             <= fptr + 1'b1;
      end
      if (alloc_en) begin
        ent[aptr].pc     <= MAX_XLEN'(alloc_pc);
        ent[aptr].filled <= 1'b0;
        aptr             <= aptr + 1'b1;
      end
      alloc_count <= alloc_count + CW'(alloc_en) - CW'(pop_en);
      fill_count  <= fill_count + CW'(fill_en) - CW'(pop_en);
    end
  end

  assign head_valid = ent[head].filled;
  assign head_pc    = ent[head].pc[XLEN-1:0];
  assign head_instr = ent[head].instr;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, imem requests, redirect drop tracking, decode queue.
// Ports: clock/reset, redirect_*, imem_req_*, imem_resp_*, out_*, occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter logic [31:0]     KILL_INSTR = DEF_KILL_INSTR
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] START_PC =
    {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_count;
  logic [CW-1:0]   alloc_count;
  logic [CW-1:0]   fill_count;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   outstanding;
  logic            req_fire;
  logic            resp_fill;
  logic            resp_drop;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  // Redirect targets are word aligned; the low bits are discarded.
  logic unused_low;
  assign unused_low = ^redirect_pc[1:0];

  assign pending     = alloc_count - fill_count;
  assign outstanding = pending + drop_count;

  // Dropped responses still occupy memory bandwidth slots, so they
  // count against the DEPTH budget alongside live entries.
  assign imem_req_valid = reset && !redirect_valid &&
    ((alloc_count + drop_count) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_count != '0);
  assign resp_fill = imem_resp_valid && (drop_count == '0) &&
                     (pending != '0);
  assign pop       = head_valid && out_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc   <= START_PC;
      drop_count <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_count <= outstanding -
        CW'(imem_resp_valid && (outstanding != '0));
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (resp_drop) begin
        drop_count <= drop_count - 1'b1;
      end
    end
  end

  fetch_entry_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .flush       (redirect_valid),
    .alloc_en    (req_fire),
    .alloc_pc    (fetch_pc),
    .fill_en     (resp_fill),
    .fill_instr  (imem_resp_data),
    .pop_en      (pop),
    .head_valid  (head_valid),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .alloc_count (alloc_count),
    .fill_count  (fill_count)
  );

  assign out_valid = head_valid;
  assign out_pc    = head_valid ? head_pc : '0;
  assign out_instr = head_valid ? head_instr : KILL_INSTR;
  assign occupancy = fill_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic,
// compared against a queue-based model of the fetch stream.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC  = 32'h0100_0000;
  localparam logic [31:0] KILL = 32'h0000_0013;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [31:0]            imem_req_addr;
  logic                   imem_resp_valid;
  logic [31:0]            imem_resp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_instr;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clock = ~clock;

  fetch_queue dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .occupancy       (occupancy)
  );

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } ment_t;

  ment_t       live[$];
  int          mq_due[$];
  logic [31:0] mq_addr[$];
  int          stale;
  logic [31:0] next_req;
  int          cyc;
  int          lat;
  int          resp_pct;
  int          stray_n;
  int          checks;
  int          errors;
  int          n_acc;
  int          n_deq;
  int          base;
  bit          last_acc;
  logic [31:0] last_acc_addr;
  logic [31:0] last_deq_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input bit do_chk);
    bit rv;
    bit from_mq;
    bit acc;
    bit deq;
    bit exp_req;
    bit exp_ov;
    int nf;
    int nu;
    rv      = 1'b0;
    from_mq = 1'b0;
    imem_resp_data = $urandom;
    if (stray_n > 0) begin
      rv = 1'b1;
      stray_n--;
    end else if (mq_due.size() > 0 && mq_due[0] <= cyc &&
                 $urandom_range(99) < resp_pct) begin
      rv = 1'b1;
      from_mq = 1'b1;
      imem_resp_data = mem(mq_addr[0]);
    end
    imem_resp_valid = rv;
    #1;
    exp_req = reset && !redirect_valid &&
              (live.size() + stale < DEPTH);
    exp_ov  = live.size() > 0 && live[0].filled;
    nf = 0;
    foreach (live[i]) if (live[i].filled) nf++;
    if (do_chk) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) chk("req_addr", imem_req_addr, next_req);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_pc", out_pc, exp_ov ? live[0].pc : 32'h0);
      chk("out_instr", out_instr,
          exp_ov ? mem(live[0].pc) : KILL);
      chk("occupancy", 32'(occupancy), 32'(nf));
    end
    acc = exp_req && imem_req_ready;
    deq = exp_ov && out_ready;
    last_acc = acc;
    last_acc_addr = next_req;
    if (deq) last_deq_pc = live[0].pc;
    @(posedge clock);
    if (!reset) begin
      live.delete();
      mq_due.delete();
      mq_addr.delete();
      stale = 0;
      next_req = RPC;
    end else begin
      if (rv) begin
        if (from_mq) begin
          void'(mq_due.pop_front());
          void'(mq_addr.pop_front());
        end
        if (stale > 0) begin
          stale--;
        end else begin
          for (int i = 0; i < live.size(); i++) begin
            if (!live[i].filled) begin
              live[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (deq) void'(live.pop_front());
      if (redirect_valid) begin
        nu = 0;
        foreach (live[i]) if (!live[i].filled) nu++;
        stale += nu;
        live.delete();
        next_req = {redirect_pc[31:2], 2'b00};
      end else if (acc) begin
        live.push_back('{pc: next_req, filled: 1'b0});
        mq_due.push_back(cyc + lat);
        mq_addr.push_back(next_req);
        next_req += 32'd4;
      end
    end
    if (acc && reset && !redirect_valid) n_acc++;
    if (deq && reset) n_deq++;
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; stale = 0;
    n_acc = 0; n_deq = 0; stray_n = 0;
    lat = 1; resp_pct = 100; next_req = RPC;
    last_deq_pc = '0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; out_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;

    @(negedge clock);
    cycle(1'b0);
    repeat (2) cycle(1'b1);

    // Reset release, ready always, 1-cycle response.
    reset = 1'b1; imem_req_ready = 1'b1; n_acc = 0;
    cycle(1'b1);
    chk("r037_addr0", last_acc ? last_acc_addr : 32'hDEAD, RPC);
    chk("r037_nv1", 32'(out_valid), 32'd0);
    cycle(1'b1);
    chk("r037_addr1", last_acc ? last_acc_addr : 32'hDEAD,
        RPC + 32'd4);
    chk("r037_v2", 32'(out_valid), 32'd1);
    chk("r037_pc", out_pc, RPC);
    cycle(1'b1);
    chk("r037_addr2", last_acc ? last_acc_addr : 32'hDEAD,
        RPC + 32'd8);

    // Decode stalled: queue fills to DEPTH and requests stop.
    repeat (6) cycle(1'b1);
    chk("r038_acc", 32'(n_acc), 32'd4);
    chk("r038_occ", 32'(occupancy), 32'd4);
    chk("r038_req0", 32'(imem_req_valid), 32'd0);
    out_ready = 1'b1;
    cycle(1'b1);
    out_ready = 1'b0; n_acc = 0;
    repeat (6) cycle(1'b1);
    chk("r038_one", 32'(n_acc), 32'd1);
    chk("r038_occ2", 32'(occupancy), 32'd4);

    // Redirect coincident with dequeue while full.
    base = n_deq;
    redirect_valid = 1'b1; redirect_pc = 32'h0200_0000;
    out_ready = 1'b1;
    cycle(1'b1);
    redirect_valid = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b0;
    chk("r040_deq", 32'(n_deq - base), 32'd1);
    chk("r040_ov", 32'(out_valid), 32'd0);
    chk("r040_occ", 32'(occupancy), 32'd0);
    chk("r040_instr", out_instr, KILL);

    // Redirect with two requests outstanding.
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (2) cycle(1'b1);
    chk("r039_out", 32'(mq_due.size()), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0103;
    cycle(1'b1);
    redirect_valid = 1'b0;
    cycle(1'b1);
    chk("r039_addr", last_acc ? last_acc_addr : 32'hDEAD,
        32'h0100_0100);
    base = n_deq;
    for (int i = 0; i < 40 && n_deq == base; i++) cycle(1'b1);
    chk("r039_deq", 32'(n_deq > base), 32'd1);
    chk("r039_pc", last_deq_pc, 32'h0100_0100);

    // PC wrap at the top of the address space.
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle(1'b1);
    redirect_valid = 1'b0;
    cycle(1'b1);
    chk("r042_top", last_acc ? last_acc_addr : 32'hDEAD,
        32'hFFFF_FFFC);
    cycle(1'b1);
    chk("r042_wrap", last_acc ? last_acc_addr : 32'hDEAD, 32'h0);

    // Reset mid-flight, then stray responses.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    imem_req_ready = 1'b0;
    cycle(1'b1);
    redirect_valid = 1'b0;
    repeat (8) cycle(1'b1);
    lat = 4; imem_req_ready = 1'b1;
    repeat (3) cycle(1'b1);
    chk("r041_out", 32'(mq_due.size()), 32'd3);
    imem_req_ready = 1'b0; reset = 1'b0;
    repeat (2) cycle(1'b1);
    reset = 1'b1; stray_n = 3;
    repeat (4) cycle(1'b1);
    chk("r041_ov", 32'(out_valid), 32'd0);
    chk("r041_occ", 32'(occupancy), 32'd0);
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    base = n_deq;
    for (int i = 0; i < 20 && n_deq == base; i++) cycle(1'b1);
    chk("r041_deq", 32'(n_deq > base), 32'd1);
    chk("r041_pc", last_deq_pc, RPC);

    // Random traffic against the model.
    resp_pct = 70;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) lat = $urandom_range(5, 1);
      imem_req_ready = ($urandom_range(3) != 0);
      out_ready      = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(39) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(499) != 0);
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
